// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types for the 7-segment scan driver
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DEAD = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_scan_driver_tick.sv
// rtl/seg_scan_driver_tick.sv - seg_tick_gen: one-cycle tick every DIV enabled cycles
module seg_tick_gen #(
    parameter int DIV   = 5000,
    parameter int DIV_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // The tick is combinational so the consumer acts on the terminal count edge itself.
    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed 7-seg scanner; SEG_SCAN_DEADTIME_EN adds blank gaps between digits
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int DIV           = 5000,
    parameter int DIV_W         = 16,
    parameter int DEAD_CYCLES   = 4,
    parameter int ACTIVE_LOW_AN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  seg_t                segs_in [N_DIGITS],
    output seg_t                seg_out,
    output logic [N_DIGITS-1:0] an_out,
    output logic [2:0]          digit_idx,
    output logic                frame_done
);

    if (N_DIGITS < 1 || N_DIGITS > 8 || DIV < 1 || DEAD_CYCLES < 1) begin : g_bad_cfg
        $error("seg_scan_driver: parameter out of range");
    end

    localparam logic [N_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW_AN != 0) ? '1 : '0;
    localparam logic [2:0]          LAST_IDX = 3'(N_DIGITS - 1);

    function automatic logic [N_DIGITS-1:0] an_sel(input logic [2:0] idx);
        logic [N_DIGITS-1:0] oh;
        for (int k = 0; k < N_DIGITS; k++) begin
            oh[k] = (idx == 3'(k));
        end
        return (ACTIVE_LOW_AN != 0) ? ~oh : oh;
    endfunction

    scan_state_t         state_q, state_d;
    logic [2:0]          digit_q, digit_d;
    seg_t                seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                frame_q, frame_d;
    // Eight entries regardless of N_DIGITS so the 3-bit digit index always addresses it exactly.
    seg_t                shadow_q [8];
    seg_t                shadow_d [8];

    logic       show_tick;
    logic       dead_tick;
    logic       advance;
    logic       wrap;
    logic [2:0] next_idx;

    seg_tick_gen #(.DIV(DIV), .DIV_W(DIV_W)) u_show_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (!en || state_q != SHOW),
        .en   (en && state_q == SHOW),
        .tick (show_tick)
    );

`ifdef SEG_SCAN_DEADTIME_EN
    seg_tick_gen #(.DIV(DEAD_CYCLES), .DIV_W(DIV_W)) u_dead_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (!en || state_q != DEAD),
        .en   (en && state_q == DEAD),
        .tick (dead_tick)
    );
`else
    assign dead_tick = 1'b0;
`endif

    assign wrap     = (digit_q == LAST_IDX);
    assign next_idx = wrap ? 3'd0 : digit_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        seg_d    = seg_q;
        an_d     = an_q;
        frame_d  = 1'b0;
        shadow_d = shadow_q;
        advance  = 1'b0;

        if (!en) begin
            state_d = IDLE;
            digit_d = 3'd0;
            seg_d   = SEG_BLANK;
            an_d    = AN_OFF;
        end else begin
            case (state_q)
                IDLE: begin
                    for (int k = 0; k < N_DIGITS; k++) begin
                        shadow_d[k] = segs_in[k];
                    end
                    state_d = SHOW;
                    digit_d = 3'd0;
                    seg_d   = segs_in[0];
                    an_d    = an_sel(3'd0);
                end
                SHOW: begin
                    if (show_tick) begin
`ifdef SEG_SCAN_DEADTIME_EN
                        state_d = DEAD;
                        seg_d   = SEG_BLANK;
                        an_d    = AN_OFF;
`else
                        advance = 1'b1;
`endif
                    end
                end
                DEAD: begin
                    if (dead_tick) begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    digit_d = 3'd0;
                    seg_d   = SEG_BLANK;
                    an_d    = AN_OFF;
                end
            endcase

            // Wrapping re-samples the inputs on the same edge so digit 0 shows the fresh byte.
            if (advance) begin
                state_d = SHOW;
                digit_d = next_idx;
                an_d    = an_sel(next_idx);
                if (wrap) begin
                    frame_d = 1'b1;
                    seg_d   = segs_in[0];
                    for (int k = 0; k < N_DIGITS; k++) begin
                        shadow_d[k] = segs_in[k];
                    end
                end else begin
                    seg_d = shadow_q[next_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            digit_q  <= 3'd0;
            seg_q    <= SEG_BLANK;
            an_q     <= AN_OFF;
            frame_q  <= 1'b0;
            shadow_q <= '{default: SEG_BLANK};
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
            shadow_q <= shadow_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign digit_idx  = digit_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - scoreboard bench for seg_scan_driver against a slot-arithmetic model
module tb_seg_scan_driver;

    localparam int N   = 8;
    localparam int DIV = 4;
    localparam int DCY = 2;
`ifdef SEG_SCAN_DEADTIME_EN
    localparam int GAP = DCY;
`else
    localparam int GAP = 0;
`endif
    localparam int SLOT  = DIV + GAP;
    localparam int FRAME = N * SLOT;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [7:0]   segs_in [N];
    logic [7:0]   seg_out;
    logic [N-1:0] an_out;
    logic [2:0]   digit_idx;
    logic         frame_done;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .N_DIGITS      (N),
        .DIV           (DIV),
        .DIV_W         (4),
        .DEAD_CYCLES   (DCY),
        .ACTIVE_LOW_AN (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .segs_in    (segs_in),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [7:0]   seg;
        logic [N-1:0] an;
        logic [2:0]   idx;
        logic         fd;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    int         n_pass  = 0;
    int         n_total = 0;
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_frame [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    endtask

    // Reference: position within the frame is plain cycle arithmetic since the scan started.
    task automatic model_edge();
        exp_t e;
        int   d;
        int   pos;
        e.seg = 8'hFF;
        e.an  = '1;
        e.idx = 3'd0;
        e.fd  = 1'b0;
        if (rst || !en) begin
            m_active = 1'b0;
        end else begin
            if (!m_active) begin
                m_active = 1'b1;
                m_t      = 0;
                m_frame  = segs_in;
            end else begin
                m_t++;
                if (m_t == FRAME) begin
                    m_t     = 0;
                    m_frame = segs_in;
                    e.fd    = 1'b1;
                end
            end
            d     = m_t / SLOT;
            pos   = m_t % SLOT;
            e.idx = 3'(d);
            if (pos < DIV) begin
                e.seg = m_frame[d];
                e.an  = ~(N'(1) << d);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_pos(input string name, input int t);
        int k = 0;
        while (!(m_active && m_t == t) && k < 400) begin
            cyc();
            k++;
        end
        check(name, 32'(k < 400), 32'd1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("seg_out", 32'(seg_out), 32'(mon_e.seg));
            check("an_out", 32'(an_out), 32'(mon_e.an));
            check("digit_idx", 32'(digit_idx), 32'(mon_e.idx));
            check("frame_done", 32'(frame_done), 32'(mon_e.fd));
            check("an_onehot", 32'($countones(~an_out) <= 1), 32'd1);
        end
    end

    int en_off;

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        for (int k = 0; k < N; k++) segs_in[k] = 8'h10 + 8'(k);
        run(3);
        rst = 1'b0;
        run(2);

        en = 1'b1;
        run(3 * FRAME);

        wait_pos("wait_cycle10", 10);
        segs_in[5] = 8'hAA;
        run(2 * FRAME);

        wait_pos("wait_digit3", 3 * SLOT + 1);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(FRAME + 5);

        wait_pos("wait_digit6", 6 * SLOT + 2);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(FRAME + 5);

        en_off = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(19) == 0) segs_in[$urandom_range(N - 1)] = 8'($urandom);
            rst = ($urandom_range(399) == 0);
            if (en_off > 0) en_off--;
            else if ($urandom_range(199) == 0) en_off = $urandom_range(5, 1);
            en = (en_off == 0);
            cyc();
        end
        rst = 1'b0;
        en  = 1'b1;
        run(FRAME);

        @(negedge clk);
        #1;
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
